// File: rtl/bt_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// bt_cmd_ctrl
//   Bluetooth command controller. A command byte from the UART receiver must
//   stay the same for HOLD_CNT consecutive cycles before it is accepted. The
//   accepted command is applied once. The controller then locks out for
//   GAP_CNT cycles and keeps the user state (volume, mp3 mode, sun mode, focus).
//
//   Optional feature macro: BT_AUTOREPEAT_EN
//     defined   - holding up/down repeats the action every GAP_CNT+1 cycles
//     undefined - every command needs a release between actions
//
// Ports
//   clk          in   1      system clock
//   rst          in   1      synchronous reset, active-high
//   blue_data    in   8      command byte from UART, level-held
//   vol_dis      in   1      1 = up/down actions blocked
//   mp3mode_dis  in   1      1 = mp3 toggle blocked
//   volum        out  VOL_W  current volume
//   mp3_mode     out  1      current mp3 mode
//   sun_mode     out  SUN_W  0 = sun, 1 = night, 2 = manual, ...
//   focus        out  1      focus toggle state
//   evt_valid    out  1      one-cycle pulse per applied command
//   evt_code     out  3      1 up, 2 down, 3 sun, 4 mp3, 5 focus
// -----------------------------------------------------------------------------
module bt_cmd_ctrl #(
    parameter int unsigned VOL_W     = 2,
    parameter int unsigned VOL_INIT  = 0,
    parameter int unsigned SUN_W     = 2,
    parameter int unsigned SUN_MODES = 3,
    parameter int unsigned HOLD_CNT  = 10,
    parameter int unsigned GAP_CNT   = 300000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       blue_data,
    input  logic             vol_dis,
    input  logic             mp3mode_dis,
    output logic [VOL_W-1:0] volum,
    output logic             mp3_mode,
    output logic [SUN_W-1:0] sun_mode,
    output logic             focus,
    output logic             evt_valid,
    output logic [2:0]       evt_code
);

    typedef enum logic [1:0] {S_IDLE, S_QUAL, S_FIRE, S_LOCK} state_t;
    typedef enum logic [2:0] {
        C_NONE  = 3'd0,
        C_UP    = 3'd1,
        C_DOWN  = 3'd2,
        C_SUN   = 3'd3,
        C_MP3   = 3'd4,
        C_FOCUS = 3'd5
    } code_t;

    localparam logic [31:0]      HOLD_W   = 32'(HOLD_CNT);
    localparam logic [31:0]      GAP_W    = 32'(GAP_CNT);
    localparam logic [VOL_W-1:0] VOL_MAX  = {VOL_W{1'b1}};
    localparam logic [VOL_W-1:0] VOL_RST  = VOL_W'(VOL_INIT);
    localparam logic [SUN_W-1:0] SUN_LAST = SUN_W'(SUN_MODES - 1);

    state_t           state_q, state_d;
    code_t            cur_q, cur_d;
    logic [31:0]      hold_q, hold_d;
    logic [31:0]      gap_q, gap_d;
    logic [VOL_W-1:0] vol_q, vol_d;
    logic             mp3_q, mp3_d;
    logic [SUN_W-1:0] sun_q, sun_d;
    logic             focus_q, focus_d;
    logic             evt_valid_q, evt_valid_d;
    logic [2:0]       evt_code_q, evt_code_d;

    code_t code;
    logic  start_qual;
`ifdef BT_AUTOREPEAT_EN
    logic  repeat_ok;
`endif

    always_comb begin
        code = C_NONE;
        case (blue_data)
            8'h01:   code = C_UP;
            8'h02:   code = C_DOWN;
            8'h04:   code = C_SUN;
            8'h08:   code = C_MP3;
            8'h40:   code = C_FOCUS;
            default: code = C_NONE;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        hold_d      = hold_q;
        gap_d       = gap_q;
        vol_d       = vol_q;
        mp3_d       = mp3_q;
        sun_d       = sun_q;
        focus_d     = focus_q;
        evt_valid_d = 1'b0;
        evt_code_d  = evt_code_q;
        start_qual  = 1'b0;
`ifdef BT_AUTOREPEAT_EN
        repeat_ok   = (code == cur_q) && ((cur_q == C_UP) || (cur_q == C_DOWN));
`endif

        case (state_q)
            S_IDLE: begin
                if (code != C_NONE) start_qual = 1'b1;
            end

            S_QUAL: begin
                if (code == cur_q) begin
                    // The sample that completes the hold goes straight to FIRE,
                    // so the action lands HOLD_CNT edges after the first sample.
                    if (hold_q >= HOLD_W - 32'd1) begin
                        state_d = S_FIRE;
                        hold_d  = HOLD_W;
                    end else begin
                        hold_d  = hold_q + 32'd1;
                    end
                end else if (code != C_NONE) begin
                    start_qual = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    hold_d  = '0;
                end
            end

            S_FIRE: begin
                case (cur_q)
                    C_UP:    if (!vol_dis && (vol_q != VOL_MAX)) vol_d = vol_q + 1'b1;
                    C_DOWN:  if (!vol_dis && (vol_q != '0))      vol_d = vol_q - 1'b1;
                    C_SUN:   sun_d = (sun_q == SUN_LAST) ? '0 : sun_q + 1'b1;
                    C_MP3:   if (!mp3mode_dis) mp3_d = ~mp3_q;
                    C_FOCUS: focus_d = ~focus_q;
                    default: ;
                endcase
                evt_valid_d = 1'b1;
                evt_code_d  = cur_q;
                gap_d       = GAP_W;
                hold_d      = '0;
                state_d     = S_LOCK;
            end

            S_LOCK: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - 32'd1;
`ifdef BT_AUTOREPEAT_EN
                    // Re-entering FIRE on the last lock cycle keeps the repeat
                    // period at GAP_CNT+1 (GAP_CNT lock cycles plus one FIRE).
                    if ((gap_q == 32'd1) && repeat_ok) state_d = S_FIRE;
`endif
                end else if (code == cur_q) begin
`ifdef BT_AUTOREPEAT_EN
                    if (repeat_ok) state_d = S_FIRE;
`endif
                end else if (code == C_NONE) begin
                    state_d = S_IDLE;
                end else begin
                    start_qual = 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase

        if (start_qual) begin
            cur_d = code;
            if (HOLD_W <= 32'd1) begin
                state_d = S_FIRE;
                hold_d  = HOLD_W;
            end else begin
                state_d = S_QUAL;
                hold_d  = 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_q       <= C_NONE;
            hold_q      <= '0;
            gap_q       <= '0;
            vol_q       <= VOL_RST;
            mp3_q       <= 1'b1;
            sun_q       <= '0;
            focus_q     <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            hold_q      <= hold_d;
            gap_q       <= gap_d;
            vol_q       <= vol_d;
            mp3_q       <= mp3_d;
            sun_q       <= sun_d;
            focus_q     <= focus_d;
            evt_valid_q <= evt_valid_d;
            evt_code_q  <= evt_code_d;
        end
    end

    assign volum     = vol_q;
    assign mp3_mode  = mp3_q;
    assign sun_mode  = sun_q;
    assign focus     = focus_q;
    assign evt_valid = evt_valid_q;
    assign evt_code  = evt_code_q;

endmodule

// File: tb/tb_bt_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bt_cmd_ctrl
//   Directed bench for bt_cmd_ctrl (HOLD_CNT=4, GAP_CNT=8, VOL_W=2,
//   SUN_MODES=3, autorepeat disabled). A run-length model of the command
//   rules is compared against the outputs after every clock edge; literal
//   checks pin latency and key state values.
// -----------------------------------------------------------------------------
module tb_bt_cmd_ctrl;

    localparam int HOLD = 4;
    localparam int GAP  = 8;
    localparam int VMAX = 3;
    localparam int NSUN = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] blue_data;
    logic       vol_dis;
    logic       mp3mode_dis;
    logic [1:0] volum;
    logic       mp3_mode;
    logic [1:0] sun_mode;
    logic       focus;
    logic       evt_valid;
    logic [2:0] evt_code;

    int nvec = 0;
    int nerr = 0;

    bt_cmd_ctrl #(
        .VOL_W    (2),
        .VOL_INIT (0),
        .SUN_W    (2),
        .SUN_MODES(3),
        .HOLD_CNT (HOLD),
        .GAP_CNT  (GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .blue_data  (blue_data),
        .vol_dis    (vol_dis),
        .mp3mode_dis(mp3mode_dis),
        .volum      (volum),
        .mp3_mode   (mp3_mode),
        .sun_mode   (sun_mode),
        .focus      (focus),
        .evt_valid  (evt_valid),
        .evt_code   (evt_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s t=%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int dec(input logic [7:0] b);
        case (b)
            8'h01:   return 1;
            8'h02:   return 2;
            8'h04:   return 3;
            8'h08:   return 4;
            8'h40:   return 5;
            default: return 0;
        endcase
    endfunction

    // ---------------- behavioural model ----------------
    // Tracks the length of the current run of identical valid codes, a
    // countdown of ignored edges after each action, and the code that must
    // be released before anything new can start.
    int m_vol = 0, m_sun = 0, m_evt_code = 0;
    bit m_mp3 = 1'b1, m_focus = 1'b0, m_evt = 1'b0;
    int run_code = 0, run_len = 0, lock_left = 0, blocked = 0, pend_code = 0;
    bit pend = 1'b0;

    always @(posedge clk) begin
        int c;
        c = dec(blue_data);
        m_evt = 1'b0;
        if (rst) begin
            m_vol = 0; m_sun = 0; m_mp3 = 1'b1; m_focus = 1'b0; m_evt_code = 0;
            run_code = 0; run_len = 0; lock_left = 0; blocked = 0; pend = 1'b0;
        end else if (pend) begin
            case (pend_code)
                1: if (!vol_dis && m_vol < VMAX) m_vol = m_vol + 1;
                2: if (!vol_dis && m_vol > 0)    m_vol = m_vol - 1;
                3: m_sun = (m_sun + 1) % NSUN;
                4: if (!mp3mode_dis) m_mp3 = !m_mp3;
                5: m_focus = !m_focus;
                default: ;
            endcase
            m_evt      = 1'b1;
            m_evt_code = pend_code;
            pend       = 1'b0;
            lock_left  = GAP;
            blocked    = pend_code;
        end else if (lock_left > 0) begin
            lock_left = lock_left - 1;
        end else if (!(blocked != 0 && c == blocked)) begin
            blocked = 0;
            if (c == 0) run_len = 0;
            else if (c == run_code && run_len > 0) run_len = run_len + 1;
            else begin
                run_code = c;
                run_len  = 1;
            end
            if (run_len == HOLD) begin
                pend      = 1'b1;
                pend_code = c;
                run_len   = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #1;
        chk("volum", int'(volum), m_vol);
        chk("mp3_mode", int'(mp3_mode), int'(m_mp3));
        chk("sun_mode", int'(sun_mode), m_sun);
        chk("focus", int'(focus), int'(m_focus));
        chk("evt_valid", int'(evt_valid), int'(m_evt));
        if (m_evt) chk("evt_code", int'(evt_code), m_evt_code);
    end

    task automatic press(input logic [7:0] b, input int hold, input int rel);
        blue_data = b;
        repeat (hold) @(negedge clk);
        blue_data = 8'h00;
        repeat (rel) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: stimulus did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; blue_data = 8'h00; vol_dis = 1'b0; mp3mode_dis = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_volum", int'(volum), 0);
        chk("rst_mp3", int'(mp3_mode), 1);
        chk("rst_sun", int'(sun_mode), 0);
        chk("rst_focus", int'(focus), 0);
        chk("rst_evt", int'(evt_valid), 0);

        // reset asserted in the middle of qualification
        rst = 1'b0; blue_data = 8'h01;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        blue_data = 8'h00;
        repeat (10) @(negedge clk);
        chk("rst_qual_volum", int'(volum), 0);

        // latency: onset before edge 0, action at edge HOLD
        blue_data = 8'h01;
        repeat (HOLD) @(posedge clk);
        #2 chk("lat_before", int'(volum), 0);
        @(posedge clk);
        #2;
        chk("lat_volum", int'(volum), 1);
        chk("lat_evt", int'(evt_valid), 1);
        chk("lat_code", int'(evt_code), 1);
        @(negedge clk);
        repeat (25) @(negedge clk);
        blue_data = 8'h00;
        repeat (14) @(negedge clk);
        chk("held30_volum", int'(volum), 1);

        press(8'h01, 6, 14); chk("up2", int'(volum), 2);
        press(8'h01, 6, 14); chk("up3", int'(volum), 3);
        press(8'h01, 6, 14); chk("up_sat", int'(volum), 3);

        // glitches
        press(8'h01, 3, 6);  chk("glitch3", int'(volum), 3);
        blue_data = 8'h01;
        repeat (2) @(negedge clk);
        press(8'h02, 4, 14); chk("switch_down", int'(volum), 2);
        press(8'h77, 20, 4);
        chk("none_vol", int'(volum), 2);
        chk("none_sun", int'(sun_mode), 0);

        // enables
        vol_dis = 1'b1;
        press(8'h01, 6, 14); chk("vol_dis", int'(volum), 2);
        vol_dis = 1'b0;
        mp3mode_dis = 1'b1;
        press(8'h08, 6, 14); chk("mp3_dis", int'(mp3_mode), 1);
        mp3mode_dis = 1'b0;
        press(8'h08, 6, 14); chk("mp3_tog", int'(mp3_mode), 0);

        // wrap / toggle
        press(8'h04, 6, 14); chk("sun1", int'(sun_mode), 1);
        press(8'h04, 6, 14); chk("sun2", int'(sun_mode), 2);
        press(8'h04, 6, 14); chk("sun_wrap", int'(sun_mode), 0);
        press(8'h40, 6, 14); chk("focus1", int'(focus), 1);
        press(8'h40, 6, 14); chk("focus0", int'(focus), 0);

        // focus then sun back-to-back: sun acts 8+1+4 edges after focus
        blue_data = 8'h40;
        repeat (HOLD + 1) @(posedge clk);
        #2;
        chk("b2b_focus", int'(focus), 1);
        chk("b2b_focus_evt", int'(evt_valid), 1);
        @(negedge clk);
        blue_data = 8'h04;
        repeat (GAP + 1 + HOLD - 1) @(posedge clk);
        #2 chk("b2b_sun_before", int'(sun_mode), 0);
        @(posedge clk);
        #2;
        chk("b2b_sun", int'(sun_mode), 1);
        chk("b2b_sun_evt", int'(evt_valid), 1);
        chk("b2b_sun_code", int'(evt_code), 3);
        @(negedge clk);
        blue_data = 8'h00;
        repeat (14) @(negedge clk);

        // reset in the middle of LOCK
        blue_data = 8'h01;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; blue_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_lock_vol", int'(volum), 0);
        chk("rst_lock_mp3", int'(mp3_mode), 1);
        chk("rst_lock_sun", int'(sun_mode), 0);
        chk("rst_lock_focus", int'(focus), 0);

        press(8'h02, 6, 14); chk("down_sat", int'(volum), 0);
        press(8'h01, 6, 14); chk("up_after_rst", int'(volum), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
